ex_mem_pipe_stage: RTL and testbench

- Parametrised EX→MEM pipeline stage for the integer core, replacing the plain always-load register.
- Carries result, write-back address, write enable and a generic memory-control field.
- Adds a valid/ready handshake, flush, an optional 2-entry skid buffer for a fully registered in_ready_o, x0 write suppression, and a saturating stall counter.
- Sits between the EX unit (upstream) and the MEM stage (downstream).

---
 rtl/core_pipe_pkg.sv | 23 ++
 rtl/ex_mem_pipe_stage_if.sv | 37 +++
 rtl/pipe_skid_buf.sv | 80 ++++++++
 rtl/ex_mem_pipe_stage.sv | 62 ++++++
 tb/tb_ex_mem_pipe_stage.sv | 170 +++++++++++++++++
 5 files changed

// File: rtl/core_pipe_pkg.sv
// Shared definitions for the integer-core pipeline registers.
// Default field widths, the EX->MEM payload layout and the x0 register index.
package core_pipe_pkg;

    localparam int DEF_DATA_W  = 32;
    localparam int DEF_WADDR_W = 5;
    localparam int DEF_CTRL_W  = 4;

    localparam int REG_ZERO = 0;

    typedef struct packed {
        logic [DEF_DATA_W-1:0]  op_c;
        logic [DEF_WADDR_W-1:0] waddr;
        logic                   we;
        logic [DEF_CTRL_W-1:0]  ctrl;
    } ex_mem_payload_t;

    // Flat width of one EX->MEM beat for arbitrary field widths.
    function automatic int payload_w(input int data_w, input int waddr_w, input int ctrl_w);
        return data_w + waddr_w + 1 + ctrl_w;
    endfunction

endpackage

// File: rtl/ex_mem_pipe_stage_if.sv
// EX->MEM handshake bus: the upstream beat, its ready, and the downstream held entry.
// valid/ready: a beat transfers on a rising edge where valid and ready are both 1.
interface ex_mem_pipe_stage_if
    import core_pipe_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int WADDR_W = DEF_WADDR_W,
    parameter int CTRL_W  = DEF_CTRL_W
);

    logic               in_valid_i;
    logic               in_ready_o;
    logic [DATA_W-1:0]  ex_op_c_i;
    logic [WADDR_W-1:0] ex_reg_waddr_i;
    logic               ex_reg_we_i;
    logic [CTRL_W-1:0]  ex_ctrl_i;

    logic               out_valid_o;
    logic               out_ready_i;
    logic [DATA_W-1:0]  ex_mem_reg_op_c_o;
    logic [WADDR_W-1:0] ex_mem_reg_reg_waddr_o;
    logic               ex_mem_reg_reg_we_o;
    logic [CTRL_W-1:0]  ex_mem_reg_ctrl_o;

    modport master (
        output in_valid_i, ex_op_c_i, ex_reg_waddr_i, ex_reg_we_i, ex_ctrl_i, out_ready_i,
        input  in_ready_o, out_valid_o, ex_mem_reg_op_c_o, ex_mem_reg_reg_waddr_o,
               ex_mem_reg_reg_we_o, ex_mem_reg_ctrl_o
    );

    modport slave (
        input  in_valid_i, ex_op_c_i, ex_reg_waddr_i, ex_reg_we_i, ex_ctrl_i, out_ready_i,
        output in_ready_o, out_valid_o, ex_mem_reg_op_c_o, ex_mem_reg_reg_waddr_o,
               ex_mem_reg_reg_we_o, ex_mem_reg_ctrl_o
    );

endinterface

// File: rtl/pipe_skid_buf.sv
// Generic valid/ready pipeline register of width W.
// SKID=1 adds a second entry so in_ready comes straight from a flop; SKID=0 is a single entry.
module pipe_skid_buf #(
    parameter int W    = 8,
    parameter bit SKID = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         m_valid;
    logic [W-1:0] m_data;
    logic         accept;
    logic         pop;

    assign accept    = in_valid & in_ready;
    assign pop       = m_valid & out_ready;
    assign out_valid = m_valid;
    assign out_data  = m_data;

    generate
        if (SKID) begin : g_skid
            logic         s_valid;
            logic [W-1:0] s_data;

            assign in_ready = ~s_valid;

            // S only fills while M is stalled, so S is always the younger beat.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    m_valid <= 1'b0;
                    m_data  <= '0;
                    s_valid <= 1'b0;
                    s_data  <= '0;
                end else if (flush) begin
                    m_valid <= 1'b0;
                    s_valid <= 1'b0;
                end else if (pop || !m_valid) begin
                    if (s_valid) begin
                        m_valid <= 1'b1;
                        m_data  <= s_data;
                        s_valid <= 1'b0;
                    end else begin
                        m_valid <= accept;
                        if (accept) begin
                            m_data <= in_data;
                        end
                    end
                end else if (accept) begin
                    s_valid <= 1'b1;
                    s_data  <= in_data;
                end
            end
        end else begin : g_single
            assign in_ready = ~m_valid | out_ready;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    m_valid <= 1'b0;
                    m_data  <= '0;
                end else if (flush) begin
                    m_valid <= 1'b0;
                end else if (accept) begin
                    m_valid <= 1'b1;
                    m_data  <= in_data;
                end else if (pop) begin
                    m_valid <= 1'b0;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/ex_mem_pipe_stage.sv
// EX->MEM pipeline stage: handshaked register with flush, x0 write suppression,
// write-enable gating by valid, and a saturating back-pressure counter.
module ex_mem_pipe_stage
    import core_pipe_pkg::*;
#(
    parameter int DATA_W        = DEF_DATA_W,
    parameter int WADDR_W       = DEF_WADDR_W,
    parameter int CTRL_W        = DEF_CTRL_W,
    parameter bit SKID          = 1'b1,
    parameter bit ZERO_SUPPRESS = 1'b1,
    parameter int CNT_W         = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush_i,
    ex_mem_pipe_stage_if.slave   bus,
    output logic [CNT_W-1:0]     stall_cnt_o
);

    localparam int PW = payload_w(DATA_W, WADDR_W, CTRL_W);

    logic          cap_we;
    logic [PW-1:0] in_data;
    logic [PW-1:0] m_data;
    logic          m_valid;

    // Writes to x0 are dropped here so MEM/WB never see them as real writes.
    assign cap_we  = ZERO_SUPPRESS ? (bus.ex_reg_we_i & (bus.ex_reg_waddr_i != WADDR_W'(REG_ZERO)))
                                   : bus.ex_reg_we_i;
    assign in_data = {bus.ex_op_c_i, bus.ex_reg_waddr_i, cap_we, bus.ex_ctrl_i};

    pipe_skid_buf #(
        .W    (PW),
        .SKID (SKID)
    ) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush_i),
        .in_valid  (bus.in_valid_i),
        .in_ready  (bus.in_ready_o),
        .in_data   (in_data),
        .out_valid (m_valid),
        .out_ready (bus.out_ready_i),
        .out_data  (m_data)
    );

    assign bus.out_valid_o            = m_valid;
    assign bus.ex_mem_reg_op_c_o      = m_data[PW-1 -: DATA_W];
    assign bus.ex_mem_reg_reg_waddr_o = m_data[CTRL_W+1 +: WADDR_W];
    assign bus.ex_mem_reg_reg_we_o    = m_valid & m_data[CTRL_W];
    assign bus.ex_mem_reg_ctrl_o      = m_data[CTRL_W-1:0];

    // Counts cycles MEM refuses a valid entry; sticks at all-ones, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_o <= '0;
        end else if (m_valid && !bus.out_ready_i && (stall_cnt_o != '1)) begin
            stall_cnt_o <= stall_cnt_o + 1'b1;
        end
    end

endmodule

// File: tb/tb_ex_mem_pipe_stage.sv
// Self-checking bench for ex_mem_pipe_stage (SKID=1, ZERO_SUPPRESS=1, CNT_W=4).
// Stage contents are modelled as an in-order queue of at most two beats.
module tb_ex_mem_pipe_stage;
    import core_pipe_pkg::*;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             flush_i = 1'b0;
    logic [CNT_W-1:0] stall_cnt_o;

    ex_mem_pipe_stage_if #(.DATA_W(32), .WADDR_W(5), .CTRL_W(4)) bus();

    ex_mem_pipe_stage #(
        .DATA_W(32), .WADDR_W(5), .CTRL_W(4),
        .SKID(1'b1), .ZERO_SUPPRESS(1'b1), .CNT_W(CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_i     (flush_i),
        .bus         (bus.slave),
        .stall_cnt_o (stall_cnt_o)
    );

    always #5 clk = ~clk;

    ex_mem_payload_t exp_q[$];
    int checks = 0;
    int errors = 0;
    int model_cnt = 0;
    bit mon_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus; entered and left 1 time unit after a rising edge.
    task automatic cyc(input bit v, input logic [31:0] op, input logic [4:0] wa, input bit we,
                       input logic [3:0] ct, input bit ordy, input bit fl, output bit acc);
        bus.in_valid_i     = v;
        bus.ex_op_c_i      = op;
        bus.ex_reg_waddr_i = wa;
        bus.ex_reg_we_i    = we;
        bus.ex_ctrl_i      = ct;
        bus.out_ready_i    = ordy & ~fl;
        flush_i            = fl;
        acc = v && (exp_q.size() < 2) && !fl;
        @(posedge clk);
        if (fl) exp_q.delete();
        else if (acc) exp_q.push_back('{op_c: op, waddr: wa, we: (we && wa != 5'd0), ctrl: ct});
        #1;
    endtask

    task automatic idle(input int n);
        bit a;
        for (int i = 0; i < n; i++) cyc(1'b0, 32'h0, 5'd0, 1'b0, 4'h0, 1'b1, 1'b0, a);
    endtask

    // Monitor: compares what the DUT presents against the model, pops on each transfer.
    always @(negedge clk) begin : monitor
        int n;
        if (mon_en && rst_n) begin
            n = exp_q.size();
            chk("out_valid", bus.out_valid_o, n != 0);
            chk("in_ready", bus.in_ready_o, n < 2);
            chk("stall_cnt", stall_cnt_o, model_cnt);
            if (n != 0) begin
                chk("op_c", bus.ex_mem_reg_op_c_o, exp_q[0].op_c);
                chk("waddr", bus.ex_mem_reg_reg_waddr_o, exp_q[0].waddr);
                chk("we", bus.ex_mem_reg_reg_we_o, exp_q[0].we);
                chk("ctrl", bus.ex_mem_reg_ctrl_o, exp_q[0].ctrl);
            end else begin
                chk("we_idle", bus.ex_mem_reg_reg_we_o, 1'b0);
            end
            if (bus.out_valid_o && bus.out_ready_i && n != 0) void'(exp_q.pop_front());
            if (n != 0 && !bus.out_ready_i && model_cnt < 15) model_cnt++;
        end
    end

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_out_valid"}, bus.out_valid_o, 1'b0);
        chk({tag, "_we"}, bus.ex_mem_reg_reg_we_o, 1'b0);
        chk({tag, "_in_ready"}, bus.in_ready_o, 1'b1);
        chk({tag, "_op_c"}, bus.ex_mem_reg_op_c_o, 32'h0);
        chk({tag, "_waddr"}, bus.ex_mem_reg_reg_waddr_o, 5'h0);
        chk({tag, "_ctrl"}, bus.ex_mem_reg_ctrl_o, 4'h0);
        chk({tag, "_stall"}, stall_cnt_o, 4'h0);
    endtask

    initial begin : stimulus
        bit a;
        bus.in_valid_i     = 1'b0;
        bus.ex_op_c_i      = '0;
        bus.ex_reg_waddr_i = '0;
        bus.ex_reg_we_i    = 1'b0;
        bus.ex_ctrl_i      = '0;
        bus.out_ready_i    = 1'b0;

        #12;
        chk_reset_outputs("por");
        @(posedge clk); #1;
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // Fill M and S, then reset asynchronously mid-cycle.
        cyc(1'b1, 32'h0000_0011, 5'd1, 1'b1, 4'h1, 1'b0, 1'b0, a);
        cyc(1'b1, 32'h0000_0022, 5'd2, 1'b1, 4'h2, 1'b0, 1'b0, a);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        model_cnt = 0;
        #1;
        chk_reset_outputs("midrst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        cyc(1'b1, 32'hA5A5_0001, 5'd3, 1'b1, 4'h2, 1'b1, 1'b0, a);
        idle(1);

        // Streaming back-to-back beats.
        for (int i = 0; i < 8; i++)
            cyc(1'b1, $urandom, 5'(i + 1), 1'b1, 4'(i), 1'b1, 1'b0, a);
        idle(2);

        // Back-pressure: beat 3 is held upstream until the stage has room.
        cyc(1'b1, 32'hB000_0001, 5'd7, 1'b1, 4'h1, 1'b0, 1'b0, a);
        cyc(1'b1, 32'hB000_0002, 5'd8, 1'b1, 4'h2, 1'b0, 1'b0, a);
        cyc(1'b1, 32'hB000_0003, 5'd9, 1'b1, 4'h3, 1'b0, 1'b0, a);
        a = 1'b0;
        for (int k = 0; k < 6 && !a; k++)
            cyc(1'b1, 32'hB000_0003, 5'd9, 1'b1, 4'h3, 1'b1, 1'b0, a);
        if (!a) chk("hold_accept_timeout", 1'b0, 1'b1);
        idle(3);

        // Flush with both entries full and a beat offered.
        cyc(1'b1, 32'hC000_0001, 5'd4, 1'b1, 4'h4, 1'b0, 1'b0, a);
        cyc(1'b1, 32'hC000_0002, 5'd5, 1'b1, 4'h5, 1'b0, 1'b0, a);
        cyc(1'b1, 32'hC000_0003, 5'd6, 1'b1, 4'h6, 1'b0, 1'b1, a);
        cyc(1'b0, 32'h0, 5'd0, 1'b0, 4'h0, 1'b0, 1'b1, a);
        idle(2);

        // x0 write suppression.
        cyc(1'b1, 32'h0000_1234, 5'd0, 1'b1, 4'h7, 1'b1, 1'b0, a);
        cyc(1'b1, 32'h0000_5678, 5'd5, 1'b1, 4'h8, 1'b1, 1'b0, a);
        idle(2);

        // Counter saturation under a long stall.
        cyc(1'b1, 32'hD000_0001, 5'd10, 1'b1, 4'h9, 1'b0, 1'b0, a);
        for (int i = 0; i < 20; i++)
            cyc(1'b0, 32'h0, 5'd0, 1'b0, 4'h0, 1'b0, 1'b0, a);
        chk("stall_saturated", stall_cnt_o, 4'hF);
        idle(3);

        // Randomised traffic with occasional flushes.
        for (int i = 0; i < 400; i++)
            cyc(1'($urandom_range(0, 1)), $urandom, 5'($urandom_range(0, 31)),
                1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                1'($urandom_range(0, 1)), ($urandom_range(0, 19) == 0), a);
        idle(4);
        chk("drain_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
